// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and default widths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_DIV_WIDTH  = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; bit_end flags the last clock of a bit.
module uart_baud_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             bit_end
);

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != WIDTH'(0)) begin
      cnt <= cnt - WIDTH'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign bit_end = (cnt == WIDTH'(0));

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter draining a show-ahead FIFO back-to-back.
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  input  logic [DIV_WIDTH-1:0]  i_baud_div,
  input  logic                  i_parity_en,
  input  logic                  i_parity_odd,
  input  logic                  i_two_stop,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  uart_state_e           state_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [IDX_W-1:0]      bit_idx_r;
  logic [DIV_WIDTH-1:0]  div_r;
  logic                  two_stop_r;
  logic                  stop_left_r;
  logic                  tx_r;
  logic                  busy_r;
  logic                  done_r;

  logic [DIV_WIDTH-1:0]  cnt_s;
  logic                  bit_end_s;
  logic                  stop_last_s;
  logic                  pop_s;
  logic                  load_s;
  logic [DIV_WIDTH-1:0]  div_norm_s;
  logic [DIV_WIDTH-1:0]  load_val_s;

`ifdef UART_TX_PARITY_EN
  logic par_en_r;
  logic par_bit_r;
`else
  logic parity_unused_s;
  assign parity_unused_s = i_parity_en ^ i_parity_odd;
`endif

  // Pop, bit-period reload and divisor normalisation.
  always_comb begin
    stop_last_s = (state_r == ST_STOP) && bit_end_s && !stop_left_r;
    pop_s       = ((state_r == ST_IDLE) || stop_last_s) && !i_fifo_empty && !i_rst;
    load_s      = pop_s || (bit_end_s && (state_r != ST_IDLE) && !stop_last_s);
    if (i_baud_div == DIV_WIDTH'(0)) begin
      div_norm_s = DIV_WIDTH'(1);
    end else begin
      div_norm_s = i_baud_div;
    end
    if (pop_s) begin
      load_val_s = div_norm_s - DIV_WIDTH'(1);
    end else begin
      load_val_s = div_r - DIV_WIDTH'(1);
    end
  end

  uart_baud_cnt #(.WIDTH(DIV_WIDTH)) u_baud_cnt (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (load_s),
    .load_val (load_val_s),
    .cnt      (cnt_s),
    .bit_end  (bit_end_s)
  );

  // Frame sequencer; o_done is raised one clock early so it lands on the last STOP clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      shift_r     <= '0;
      bit_idx_r   <= '0;
      div_r       <= '0;
      two_stop_r  <= 1'b0;
      stop_left_r <= 1'b0;
      tx_r        <= UART_IDLE_LEVEL;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_r    <= 1'b0;
      par_bit_r   <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      if (pop_s) begin
        shift_r    <= i_fifo_data;
        div_r      <= div_norm_s;
        two_stop_r <= i_two_stop;
`ifdef UART_TX_PARITY_EN
        par_en_r   <= i_parity_en;
        par_bit_r  <= calc_parity(i_fifo_data, i_parity_odd);
`endif
        state_r    <= ST_START;
        tx_r       <= UART_START_LEVEL;
        busy_r     <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            tx_r   <= UART_IDLE_LEVEL;
            busy_r <= 1'b0;
          end
          ST_START: begin
            if (bit_end_s) begin
              state_r   <= ST_DATA;
              tx_r      <= shift_r[0];
              bit_idx_r <= IDX_W'(DATA_WIDTH - 1);
            end
          end
          ST_DATA: begin
            if (bit_end_s) begin
              if (bit_idx_r != IDX_W'(0)) begin
                shift_r   <= shift_r >> 1;
                tx_r      <= shift_r[1];
                bit_idx_r <= bit_idx_r - IDX_W'(1);
`ifdef UART_TX_PARITY_EN
              end else if (par_en_r) begin
                state_r <= ST_PARITY;
                tx_r    <= par_bit_r;
`endif
              end else begin
                state_r     <= ST_STOP;
                tx_r        <= UART_IDLE_LEVEL;
                stop_left_r <= two_stop_r;
                done_r      <= !two_stop_r && (div_r == DIV_WIDTH'(1));
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            if (bit_end_s) begin
              state_r     <= ST_STOP;
              tx_r        <= UART_IDLE_LEVEL;
              stop_left_r <= two_stop_r;
              done_r      <= !two_stop_r && (div_r == DIV_WIDTH'(1));
            end
          end
`endif
          ST_STOP: begin
            if (bit_end_s) begin
              if (stop_left_r) begin
                stop_left_r <= 1'b0;
                done_r      <= (div_r == DIV_WIDTH'(1));
              end else begin
                state_r <= ST_IDLE;
                tx_r    <= UART_IDLE_LEVEL;
                busy_r  <= 1'b0;
              end
            end else begin
              done_r <= !stop_left_r && (cnt_s == DIV_WIDTH'(1));
            end
          end
          default: begin
            state_r <= ST_IDLE;
            tx_r    <= UART_IDLE_LEVEL;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_fifo_rd = pop_s;
  assign o_tx      = tx_r;
  assign o_busy    = busy_r;
  assign o_done    = done_r;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: waveform-queue model checked every cycle plus literal frame checks.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        tx;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo_q[$];
  logic [1:0] exp_q[$];
  logic       pop_pend = 1'b0;

  logic cap [0:511];
  int   cap_n = 0;
  int   busy_cycles = 0;
  int   done_cnt = 0;
  int   rd_cnt = 0;
  int   done_at [0:7];

  uart_tx_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd    (fifo_rd),
    .i_baud_div   (baud_div),
    .i_parity_en  (parity_en),
    .i_parity_odd (parity_odd),
    .i_two_stop   (two_stop),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  // Expected line waveform of one frame, one queue entry {tx, done} per clock.
  task automatic push_frame(input logic [7:0] d, input logic [15:0] bd, input logic pe,
                            input logic po, input logic ts);
    logic bits[$];
    int   div;
    div = (bd == 16'd0) ? 1 : int'(bd);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PAR_ON && pe) bits.push_back((^d) ^ po);
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < div; k++) exp_q.push_back({bits[i], 1'b0});
    exp_q[exp_q.size()-1] = 2'b11;
  endtask

  // Per-cycle compare against the model, plus measurement for the literal checks.
  always @(negedge clk) begin
    logic [1:0] e;
    logic etx, ebusy, edone, mrd;
    if (rst) begin
      exp_q.delete();
      etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      etx = e[1]; ebusy = 1'b1; edone = e[0];
    end else begin
      etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
    end
    chk("tx", {31'd0, tx}, {31'd0, etx});
    chk("busy", {31'd0, busy}, {31'd0, ebusy});
    chk("done", {31'd0, done}, {31'd0, edone});
    mrd = !rst && (exp_q.size() == 0) && (fifo_q.size() != 0);
    chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, mrd});
    if (busy) begin
      if (cap_n < 512) cap[cap_n] = tx;
      cap_n++;
      busy_cycles++;
    end
    if (done) begin
      if (done_cnt < 8) done_at[done_cnt] = busy_cycles;
      done_cnt++;
    end
    if (fifo_rd) rd_cnt++;
    if (mrd) begin
      push_frame(fifo_q[0], baud_div, parity_en, parity_odd, two_stop);
      pop_pend = 1'b1;
    end
  end

  // FIFO pop lands just after the edge that latched the head word.
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_pend) begin
      void'(fifo_q.pop_front());
      pop_pend = 1'b0;
      fifo_sync();
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic begin_test();
    cap_n = 0; busy_cycles = 0; done_cnt = 0; rd_cnt = 0;
    for (int i = 0; i < 8; i++) done_at[i] = 0;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    fifo_sync();
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (!busy && fifo_q.size() == 0 && !pop_pend) begin
        ok = 1'b1;
        break;
      end
    end
    step(2);
    chk({name, "_idle_timeout"}, {31'd0, ok}, 32'd1);
  endtask

  // Sample the first clock of each bit and compare against a transmit-order pattern.
  task automatic check_bits(input string name, input int div, input int nbits,
                            input logic [31:0] pat);
    for (int i = 0; i < nbits; i++)
      chk($sformatf("%s_bit%0d", name, i), {31'd0, cap[i*div]}, {31'd0, pat[nbits-1-i]});
  endtask

  initial begin
    rst = 1'b1; baud_div = 16'd4; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    fifo_sync();
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
    step(3);
    rst = 1'b0;
    step(2);

    // 1: 0xA5, div 4, no parity, one stop
    begin_test();
    push(8'hA5);
    wait_idle("t1", 200);
    chk("t1_len", busy_cycles, 32'd40);
    chk("t1_rd", rd_cnt, 32'd1);
    chk("t1_done_cnt", done_cnt, 32'd1);
    chk("t1_done_at", done_at[0], 32'd40);
    check_bits("t1", 4, 10, 32'b0101001011);

    // 2: 0xA5, div 2, parity even then odd
    baud_div = 16'd2; parity_en = 1'b1; parity_odd = 1'b0;
    begin_test();
    push(8'hA5);
    wait_idle("t2e", 200);
    chk("t2e_len", busy_cycles, PAR_ON ? 32'd22 : 32'd20);
    check_bits("t2e", 2, 9, 32'b010100101);
    chk("t2e_par", {31'd0, cap[18]}, PAR_ON ? 32'd0 : 32'd1);
    parity_odd = 1'b1;
    begin_test();
    push(8'hA5);
    wait_idle("t2o", 200);
    chk("t2o_len", busy_cycles, PAR_ON ? 32'd22 : 32'd20);
    chk("t2o_par", {31'd0, cap[18]}, 32'd1);
    parity_en = 1'b0; parity_odd = 1'b0;

    // 3: back-to-back 0x00, 0xFF at div 4
    baud_div = 16'd4;
    begin_test();
    push(8'h00);
    push(8'hFF);
    wait_idle("t3", 300);
    chk("t3_len", busy_cycles, 32'd80);
    chk("t3_rd", rd_cnt, 32'd2);
    chk("t3_done_cnt", done_cnt, 32'd2);
    chk("t3_done0", done_at[0], 32'd40);
    chk("t3_done1", done_at[1], 32'd80);
    check_bits("t3", 4, 20, 32'b0000000001_0111111111);

    // 4: div 0 behaves as 1, two stop bits
    baud_div = 16'd0; two_stop = 1'b1;
    begin_test();
    push(8'h01);
    wait_idle("t4", 100);
    chk("t4_len", busy_cycles, 32'd11);
    chk("t4_done_at", done_at[0], 32'd11);
    check_bits("t4", 1, 11, 32'b01000000011);
    two_stop = 1'b0;

    // 5: reset during data bit 3 of 0x3C
    baud_div = 16'd4;
    begin_test();
    push(8'h3C);
    for (int i = 0; i < 50 && !busy; i++) step(1);
    chk("t5_started", {31'd0, busy}, 32'd1);
    step(17);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx", {31'd0, tx}, 32'd1);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_done", {31'd0, done}, 32'd0);
    step(3);
    rst = 1'b0;
    begin_test();
    step(20);
    chk("t5_rd_after", rd_cnt, 32'd0);
    chk("t5_busy_after", busy_cycles, 32'd0);
    chk("t5_tx_after", {31'd0, tx}, 32'd1);

    // 6: divisor change mid-frame applies only to the next frame
    baud_div = 16'd4;
    begin_test();
    push(8'h55);
    push(8'h0F);
    for (int i = 0; i < 50 && !busy; i++) step(1);
    step(5);
    baud_div = 16'd8;
    wait_idle("t6", 400);
    chk("t6_len", busy_cycles, 32'd120);
    chk("t6_done0", done_at[0], 32'd40);
    chk("t6_done1", done_at[1], 32'd120);
    check_bits("t6a", 4, 10, 32'b0101010101);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t6b_bit%0d", i), {31'd0, cap[40 + i*8]},
          {31'd0, (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : (i <= 4) ? 1'b1 : 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
UART transmit engine on the read side of the TX byte FIFO. It pops bytes from a show-ahead FIFO and serialises each one onto the TX line as start, data (LSB first), optional parity and stop bits, with a runtime-programmable bit period. Consecutive FIFO entries are sent back-to-back with no idle gap, and the line returns to idle-high when the FIFO drains.

Parameters:
DATA_WIDTH, 8, bits per character.
DIV_WIDTH, 16, width of the bit-period divisor.

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
i_fifo_data  input  DATA_WIDTH  FIFO head word; valid while i_fifo_empty=0, show-ahead/combinational
i_fifo_empty  input  1  FIFO empty flag
o_fifo_rd  output  1  pop strobe, one cycle per byte
i_baud_div  input  DIV_WIDTH  clocks per bit; 0 treated as 1
i_parity_en  input  1  append parity bit
i_parity_odd  input  1  1=odd, 0=even parity
i_two_stop  input  1  1=two stop bits, 0=one
o_tx  output  1  serial line, idle high
o_busy  output  1  high while a frame is in progress
o_done  output  1  one-cycle pulse on the last clock of each frame

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted: o_tx=1, o_busy=0, o_done=0, o_fifo_rd=0, state=IDLE, all counters 0.
- States: IDLE, START, DATA, PARITY, STOP.
- o_fifo_rd is combinational: (state==IDLE or last clock of STOP) && !i_fifo_empty && !i_rst.
- Pop edge: on the clock edge where o_fifo_rd=1, the block latches:
  - i_fifo_data into the shift register;
  - i_baud_div (0 maps to 1), i_parity_en, i_parity_odd and i_two_stop into frame-config registers.
  - The state goes to START.
- Config changes mid-frame have no effect on the current frame.
- o_tx is registered: it drives 0 from the cycle after the pop edge. Latency from pop to start-bit is one clock.
- Each bit lasts exactly div clocks. The bit counter runs div-1 down to 0; a bit ends when the counter is 0.
- START: 1 bit of o_tx=0, then DATA.
- DATA: DATA_WIDTH bits, LSB first, shifted right.
  - Next state is PARITY if parity is enabled, else STOP.
- PARITY: 1 bit. Value = XOR of the data bits, XORed with the latched parity_odd.
- STOP: o_tx=1 for 1 or 2 bits, per the latched two_stop.
  - o_done pulses on its final clock.
  - On that final clock, if the FIFO is non-empty, pop and go to START: no idle gap.
  - Otherwise go to IDLE.
- o_busy = (state != IDLE), registered alongside the state.
- Frame length = div × (1 + DATA_WIDTH + parity + stop count) clocks.
- If i_fifo_empty asserts mid-frame, the current frame completes normally.
- Reset mid-frame aborts the frame immediately: o_tx=1 asynchronously; the interrupted byte is lost (already popped).
- Counter widths: the bit-period counter is DIV_WIDTH bits; the data-bit index is $clog2(DATA_WIDTH)+1 bits. No wrap occurs within a legal frame.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: PARITY state and parity logic are present; i_parity_en and i_parity_odd behave as above.
- Undefined: i_parity_en and i_parity_odd remain ports but are ignored, PARITY state is not synthesised, and DATA always proceeds to STOP.

Decomposition:
- Shared package uart_pkg holds:
  - state enum encoding (IDLE/START/DATA/PARITY/STOP);
  - constants UART_IDLE_LEVEL=1, UART_START_LEVEL=0;
  - default DATA_WIDTH and DIV_WIDTH.
- One sub-module is natural: uart_baud_cnt, a loadable down-counter with a bit_end flag. It is reusable by the future RX engine.

Test Plan:
1. FIFO holds 0xA5, div=4, no parity, 1 stop:
   - o_fifo_rd pulses once;
   - o_tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks (40 clocks total);
   - o_done pulses at clock 40; line idles high afterwards.
2. 0xA5, div=2, parity enabled:
   - even: parity bit=0; odd: parity bit=1;
   - frame = 22 clocks.
3. FIFO holds 0x00 then 0xFF, div=4, 1 stop:
   - second pop coincides with the last STOP clock of frame 1;
   - o_tx continuous with no idle gap; 80 clocks total; two o_done pulses.
4. i_baud_div=0, byte 0x01, two stop bits: each bit is 1 clock; frame = 11 clocks.
5. Assert i_rst in the DATA state (bit 3) of byte 0x3C:
   - o_tx=1, o_busy=0 immediately;
   - after release with the FIFO empty, no o_fifo_rd and the line stays high.
6. Change i_baud_div from 4 to 8 mid-frame: the current frame keeps 4-clock bits and the next frame uses 8-clock bits.
